// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: latches one decoded instruction, waits out channel hazards on a busy
// scoreboard, reads needed channel operands one at a time and hands the bundle to execute.
module operand_fetch_stage #(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int ctrl_width = 48
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(n_blocks)-1:0]   block_in,
    input  logic [3:0]                    src_a_in,
    input  logic [3:0]                    src_b_in,
    input  logic [3:0]                    src_c_in,
    input  logic                          src_a_reg_in,
    input  logic                          src_b_reg_in,
    input  logic                          src_c_reg_in,
    input  logic                          arg_a_needed_in,
    input  logic                          arg_b_needed_in,
    input  logic                          arg_c_needed_in,
    input  logic [3:0]                    dest_in,
    input  logic                          writes_channel_in,
    input  logic [data_width-1:0]         register_0_in,
    input  logic [data_width-1:0]         register_1_in,
    input  logic [ctrl_width-1:0]         ctrl_in,
    output logic [3:0]                    ch_read_addr,
    input  logic [data_width-1:0]         ch_read_val,
    input  logic                          wb_valid,
    input  logic [3:0]                    wb_dest,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(n_blocks)-1:0]   block_out,
    output logic [3:0]                    dest_out,
    output logic                          writes_channel_out,
    output logic [ctrl_width-1:0]         ctrl_out,
    output logic [data_width-1:0]         op_a_out,
    output logic [data_width-1:0]         op_b_out,
    output logic [data_width-1:0]         op_c_out
);
    localparam int bw = $clog2(n_blocks);

    typedef enum logic [1:0] {IDLE, CHECK, READ, CAPTURE} state_t;
    state_t state_reg, state_next;

    logic [2:0][3:0]            src_in, src_reg, src_next;
    logic [2:0]                 is_reg_in, needed_in, chan_in, op_hazard;
    logic [2:0][data_width-1:0] op_reg, op_next;
    logic [2:0]                 pending_reg, pending_next, rem_mask;
    logic [1:0]                 cur_reg, cur_next, first_pend, first_rem;
    logic [3:0]                 addr_reg, addr_next;
    logic                       out_valid_reg, out_valid_next;
    logic [15:0]                busy_reg, busy_next;
    logic [bw-1:0]              block_reg;
    logic [3:0]                 dest_reg;
    logic                       writes_reg;
    logic [ctrl_width-1:0]      ctrl_reg;
    logic                       accept, consume, hazard, finish, capture_en;

    function automatic logic [1:0] first_set(input logic [2:0] m);
        first_set = m[0] ? 2'd0 : (m[1] ? 2'd1 : 2'd2);
    endfunction

    assign src_in    = {src_c_in, src_b_in, src_a_in};
    assign is_reg_in = {src_c_reg_in, src_b_reg_in, src_a_reg_in};
    assign needed_in = {arg_c_needed_in, arg_b_needed_in, arg_a_needed_in};

    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_reg && out_ready;

    // pending_reg holds the channel-sourced operands still to be read, in order a,b,c
    assign rem_mask   = pending_reg & ~(3'b001 << cur_reg);
    assign first_pend = first_set(pending_reg);
    assign first_rem  = first_set(rem_mask);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_opnd
            assign chan_in[gi]   = needed_in[gi] && !is_reg_in[gi];
            assign op_hazard[gi] = pending_reg[gi] && busy_reg[src_reg[gi]];
            assign src_next[gi]  = accept ? src_in[gi] : src_reg[gi];
            assign op_next[gi]   = accept ?
                                   ((!needed_in[gi] || !is_reg_in[gi]) ? '0 :
                                    (src_in[gi][0] ? register_1_in : register_0_in)) :
                                   ((capture_en && cur_reg == 2'(gi)) ? ch_read_val : op_reg[gi]);
        end
        // Set by a consumed channel-writing result takes priority over a same-cycle writeback
        for (gi = 0; gi < 16; gi++) begin : g_busy
            assign busy_next[gi] = (consume && writes_reg && dest_reg == 4'(gi)) ? 1'b1 :
                                   (wb_valid && wb_dest == 4'(gi))              ? 1'b0 :
                                   busy_reg[gi];
        end
    endgenerate

    assign hazard = (|op_hazard) || (writes_reg && busy_reg[dest_reg]);

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        cur_next     = cur_reg;
        addr_next    = addr_reg;
        finish       = 1'b0;
        capture_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next   = CHECK;
                    pending_next = chan_in;
                end
            end
            CHECK: begin
                if (!hazard) begin
                    if (pending_reg != 3'b000) begin
                        cur_next   = first_pend;
                        addr_next  = src_reg[first_pend];
                        state_next = READ;
                    end else begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            READ: state_next = CAPTURE;
            CAPTURE: begin
                capture_en   = 1'b1;
                pending_next = rem_mask;
                if (rem_mask != 3'b000) begin
                    cur_next   = first_rem;
                    addr_next  = src_reg[first_rem];
                    state_next = READ;
                end else begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid_next = finish ? 1'b1 : (consume ? 1'b0 : out_valid_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            cur_reg       <= '0;
            addr_reg      <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= '0;
            src_reg       <= '0;
            op_reg        <= '0;
            block_reg     <= '0;
            dest_reg      <= '0;
            writes_reg    <= 1'b0;
            ctrl_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            cur_reg       <= cur_next;
            addr_reg      <= addr_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            src_reg       <= src_next;
            op_reg        <= op_next;
            if (accept) begin
                block_reg  <= block_in;
                dest_reg   <= dest_in;
                writes_reg <= writes_channel_in;
                ctrl_reg   <= ctrl_in;
            end
        end
    end

    assign out_valid          = out_valid_reg;
    assign ch_read_addr       = addr_reg;
    assign block_out          = block_reg;
    assign dest_out           = dest_reg;
    assign writes_channel_out = writes_reg;
    assign ctrl_out           = ctrl_reg;
    assign op_a_out           = op_reg[0];
    assign op_b_out           = op_reg[1];
    assign op_c_out           = op_reg[2];

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus random traffic, all checked against a
// transaction-level model of hazards, latency, scoreboard and operand values.
module tb_operand_fetch_stage;
    localparam int DW = 16;
    localparam int NB = 256;
    localparam int CW = 48;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] block_in = '0;
    logic [3:0]    src_a_in = '0, src_b_in = '0, src_c_in = '0;
    logic          src_a_reg_in = 1'b0, src_b_reg_in = 1'b0, src_c_reg_in = 1'b0;
    logic          arg_a_needed_in = 1'b0, arg_b_needed_in = 1'b0, arg_c_needed_in = 1'b0;
    logic [3:0]    dest_in = '0;
    logic          writes_channel_in = 1'b0;
    logic [DW-1:0] register_0_in = '0, register_1_in = '0;
    logic [CW-1:0] ctrl_in = '0;
    logic [3:0]    ch_read_addr;
    logic [DW-1:0] ch_read_val;
    logic          wb_valid = 1'b0;
    logic [3:0]    wb_dest = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] block_out;
    logic [3:0]    dest_out;
    logic          writes_channel_out;
    logic [CW-1:0] ctrl_out;
    logic [DW-1:0] op_a_out, op_b_out, op_c_out;

    operand_fetch_stage #(.data_width(DW), .n_blocks(NB), .ctrl_width(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .src_a_in(src_a_in), .src_b_in(src_b_in), .src_c_in(src_c_in),
        .src_a_reg_in(src_a_reg_in), .src_b_reg_in(src_b_reg_in), .src_c_reg_in(src_c_reg_in),
        .arg_a_needed_in(arg_a_needed_in), .arg_b_needed_in(arg_b_needed_in),
        .arg_c_needed_in(arg_c_needed_in), .dest_in(dest_in), .writes_channel_in(writes_channel_in),
        .register_0_in(register_0_in), .register_1_in(register_1_in), .ctrl_in(ctrl_in),
        .ch_read_addr(ch_read_addr), .ch_read_val(ch_read_val), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out),
        .dest_out(dest_out), .writes_channel_out(writes_channel_out), .ctrl_out(ctrl_out),
        .op_a_out(op_a_out), .op_b_out(op_b_out), .op_c_out(op_c_out)
    );

    always #5 clk = ~clk;

    // channel register file with one-cycle read latency
    logic [DW-1:0] rf [16];
    always @(posedge clk) ch_read_val <= rf[ch_read_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [BW-1:0]        block;
        logic [3:0]           dest;
        logic                 wr;
        logic [CW-1:0]        ctrl;
        logic [2:0][DW-1:0]   op;
        logic [2:0][3:0]      src;
        logic [2:0]           chan;
    } instr_t;

    bit     m_busy [16];
    bit     m_live = 0;
    bit     m_inflight, m_in_check, m_out_valid;
    int     m_done_edge;
    instr_t m_cur, m_out;
    bit     m_cons, m_acc, m_fin, m_rdy, m_conflict;
    int     m_k;
    logic [2:0][3:0] m_s;
    logic [2:0]      m_isreg, m_need;

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 0;
            m_inflight = 0; m_in_check = 0; m_out_valid = 0; m_done_edge = -1;
            m_live = 1;
        end else if (m_live) begin
            m_rdy = !m_inflight && (!m_out_valid || out_ready);
            check_eq("in_ready", in_ready, m_rdy);
            check_eq("out_valid", out_valid, m_out_valid);
            if (m_out_valid && out_valid) begin
                check_eq("block_out", block_out, m_out.block);
                check_eq("dest_out", dest_out, m_out.dest);
                check_eq("writes_out", writes_channel_out, m_out.wr);
                check_eq("ctrl_out", ctrl_out, m_out.ctrl);
                check_eq("op_a", op_a_out, m_out.op[0]);
                check_eq("op_b", op_b_out, m_out.op[1]);
                check_eq("op_c", op_c_out, m_out.op[2]);
            end
            m_cons = m_out_valid && out_ready;
            m_acc  = in_valid && m_rdy;
            m_fin  = 0;
            if (m_cons)
                $display("txn cyc=%0d block=%h dest=%0d wr=%0b a=%h b=%h c=%h",
                         cyc + 1, block_out, dest_out, writes_channel_out, op_a_out, op_b_out, op_c_out);
            // hazard test sees the scoreboard as it stood before this edge
            if (m_inflight && m_in_check) begin
                m_conflict = m_cur.wr && m_busy[m_cur.dest];
                m_k = 0;
                for (int i = 0; i < 3; i++) begin
                    if (m_cur.chan[i]) begin
                        m_k++;
                        if (m_busy[m_cur.src[i]]) m_conflict = 1;
                    end
                end
                if (!m_conflict) begin
                    m_done_edge = cyc + 1 + 2 * m_k;
                    m_in_check  = 0;
                end
            end
            if (wb_valid) m_busy[wb_dest] = 0;
            if (m_cons && m_out.wr) m_busy[m_out.dest] = 1;
            if (m_inflight && !m_in_check && m_done_edge == cyc + 1) begin
                m_fin = 1;
                m_inflight = 0;
                m_out = m_cur;
            end
            m_out_valid = m_fin ? 1'b1 : (m_cons ? 1'b0 : m_out_valid);
            if (m_acc) begin
                m_s     = {src_c_in, src_b_in, src_a_in};
                m_isreg = {src_c_reg_in, src_b_reg_in, src_a_reg_in};
                m_need  = {arg_c_needed_in, arg_b_needed_in, arg_a_needed_in};
                m_cur.block = block_in;
                m_cur.dest  = dest_in;
                m_cur.wr    = writes_channel_in;
                m_cur.ctrl  = ctrl_in;
                m_cur.src   = m_s;
                for (int i = 0; i < 3; i++) begin
                    m_cur.chan[i] = m_need[i] && !m_isreg[i];
                    if (!m_need[i])      m_cur.op[i] = '0;
                    else if (m_isreg[i]) m_cur.op[i] = m_s[i][0] ? register_1_in : register_0_in;
                    else                 m_cur.op[i] = rf[m_s[i]];
                end
                m_inflight = 1;
                m_in_check = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [BW-1:0] blk, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] sc, input logic [2:0] isreg, input logic [2:0] need,
                        input logic [3:0] dst, input logic wr, input logic [DW-1:0] r0,
                        input logic [DW-1:0] r1, output int e0);
        block_in = blk; src_a_in = sa; src_b_in = sb; src_c_in = sc;
        {src_c_reg_in, src_b_reg_in, src_a_reg_in} = isreg;
        {arg_c_needed_in, arg_b_needed_in, arg_a_needed_in} = need;
        dest_in = dst; writes_channel_in = wr; register_0_in = r0; register_1_in = r1;
        ctrl_in = CW'({$urandom(), $urandom()});
        in_valid = 1'b1;
        e0 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                e0 = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        if (e0 < 0) check_eq("accept_timeout", 0, 1);
    endtask

    task automatic wait_out(output int edge_no);
        edge_no = -1;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                edge_no = cyc;
                break;
            end
            step(1);
        end
        if (edge_no < 0) check_eq("out_timeout", 0, 1);
    endtask

    int e0, eo, n;
    logic [CW-1:0] exp_ctrl;

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = DW'($urandom());
        rf[3] = 16'h0011;
        rf[5] = 16'h0022;

        // reset state
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_addr", ch_read_addr, 0);
        check_eq("rst_ops", {op_a_out, op_b_out, op_c_out}, 0);
        check_eq("rst_fields", {block_out, dest_out, writes_channel_out}, 0);
        check_eq("rst_ctrl", ctrl_out, 0);

        // two channel operands: reads 3 then 5, result four cycles after the check
        out_ready = 1'b1;
        send(8'h01, 4'd3, 4'd5, 4'd0, 3'b000, 3'b011, 4'd0, 1'b0, '0, '0, e0);
        step(1);
        check_eq("t1_addr_a", ch_read_addr, 4'd3);
        step(2);
        check_eq("t1_addr_b", ch_read_addr, 4'd5);
        wait_out(eo);
        check_eq("t1_latency", eo - e0, 5);
        check_eq("t1_ops", {op_a_out, op_b_out, op_c_out}, {16'h0011, 16'h0022, 16'h0000});

        // register-only operand: no regfile access, result one cycle after accept
        send(8'h02, 4'd1, 4'd0, 4'd0, 3'b001, 3'b001, 4'd0, 1'b0, 16'h0BAD, 16'h7FFF, e0);
        wait_out(eo);
        check_eq("t2_latency", eo - e0, 1);
        check_eq("t2_op_a", op_a_out, 16'h7FFF);
        check_eq("t2_addr_hold", ch_read_addr, 4'd5);

        // read-after-write stall released by writeback
        send(8'h03, 4'd0, 4'd0, 4'd0, 3'b000, 3'b000, 4'd4, 1'b1, '0, '0, e0);
        wait_out(eo);
        send(8'h04, 4'd4, 4'd0, 4'd0, 3'b000, 3'b001, 4'd0, 1'b0, '0, '0, e0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check_eq("t3_stalled", out_valid, 0);
        end
        wb_valid = 1'b1; wb_dest = 4'd4;
        n = cyc + 1;
        step(1);
        wb_valid = 1'b0;
        wait_out(eo);
        check_eq("t3_release", eo - n, 3);
        check_eq("t3_op_a", op_a_out, rf[4]);

        // backpressure: output frozen, no new accept
        step(1);
        out_ready = 1'b0;
        send(8'h5A, 4'd0, 4'd0, 4'd0, 3'b010, 3'b010, 4'd9, 1'b0, 16'h1234, 16'h5678, e0);
        exp_ctrl = ctrl_in;
        in_valid = 1'b1;
        wait_out(eo);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_eq("t4_hold_valid", out_valid, 1);
            check_eq("t4_hold_ready", in_ready, 0);
            check_eq("t4_hold_data", {block_out, op_a_out, op_b_out, op_c_out},
                     {8'h5A, 16'h0000, 16'h1234, 16'h0000});
            check_eq("t4_hold_ctrl", ctrl_out, exp_ctrl);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("t4_ready_same_cycle", in_ready, 1);
        step(1);
        check_eq("t4_consumed", out_valid, 0);

        // set on consume beats a same-cycle writeback to the same channel
        out_ready = 1'b0;
        send(8'h07, 4'd0, 4'd0, 4'd0, 3'b000, 3'b000, 4'd7, 1'b1, '0, '0, e0);
        wait_out(eo);
        out_ready = 1'b1; wb_valid = 1'b1; wb_dest = 4'd7;
        step(1);
        wb_valid = 1'b0;
        send(8'h08, 4'd7, 4'd0, 4'd0, 3'b000, 3'b001, 4'd0, 1'b0, '0, '0, e0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check_eq("t5_stalled", out_valid, 0);
        end
        wb_valid = 1'b1; wb_dest = 4'd7;
        n = cyc + 1;
        step(1);
        wb_valid = 1'b0;
        wait_out(eo);
        check_eq("t5_release", eo - n, 3);

        // reset mid-read clears scoreboard and output
        step(1);
        send(8'h09, 4'd0, 4'd0, 4'd0, 3'b000, 3'b000, 4'd2, 1'b1, '0, '0, e0);
        wait_out(eo);
        send(8'h0A, 4'd3, 4'd0, 4'd0, 3'b000, 3'b001, 4'd0, 1'b0, '0, '0, e0);
        step(2);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check_eq("t6_out_valid", out_valid, 0);
        check_eq("t6_in_ready", in_ready, 1);
        send(8'h0B, 4'd2, 4'd0, 4'd0, 3'b000, 3'b001, 4'd0, 1'b0, '0, '0, e0);
        wait_out(eo);
        check_eq("t6_no_stall", eo - e0, 3);
        check_eq("t6_op_a", op_a_out, rf[2]);

        // random traffic
        step(1);
        for (int i = 0; i < 600; i++) begin
            in_valid          = ($urandom_range(0, 1) == 1);
            block_in          = BW'($urandom());
            src_a_in          = 4'($urandom_range(0, 7));
            src_b_in          = 4'($urandom_range(0, 7));
            src_c_in          = 4'($urandom_range(0, 7));
            {src_c_reg_in, src_b_reg_in, src_a_reg_in}          = 3'($urandom());
            {arg_c_needed_in, arg_b_needed_in, arg_a_needed_in} = 3'($urandom());
            dest_in           = 4'($urandom_range(0, 7));
            writes_channel_in = ($urandom_range(0, 1) == 1);
            register_0_in     = DW'($urandom());
            register_1_in     = DW'($urandom());
            ctrl_in           = CW'({$urandom(), $urandom()});
            out_ready         = ($urandom_range(0, 3) != 0);
            wb_valid          = ($urandom_range(0, 2) == 0);
            wb_dest           = 4'($urandom_range(0, 7));
            step(1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            wb_valid = 1'b1;
            wb_dest  = 4'(i % 8);
            step(1);
        end
        wb_valid = 1'b0;
        step(2);
        check_eq("drain_out_valid", out_valid, 0);
        check_eq("drain_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
